// File: rtl/result_fifo_pkg.sv
// result_fifo_acc shared definitions: default sizes and the
// per-cycle FIFO operation encoding.
package result_fifo_pkg;

  localparam int W_DEF     = 8;
  localparam int DEPTH_DEF = 4;
  localparam int ACC_W_DEF = 16;
  localparam int PTR_W_DEF = $clog2(DEPTH_DEF);

  typedef enum logic [2:0] {
    OP_IDLE = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_XFER = 3'd3,
    OP_DROP = 3'd4,
    OP_CLR  = 3'd5
  } fifo_op_e;

  function automatic fifo_op_e op_encode(
    input logic clr,
    input logic push,
    input logic pop,
    input logic drop
  );
    fifo_op_e op;
    op = OP_IDLE;
    unique case (1'b1)
      clr:                  op = OP_CLR;
      !clr && push && pop:  op = OP_XFER;
      !clr && push && !pop: op = OP_PUSH;
      !clr && pop && !push: op = OP_POP;
      !clr && drop:         op = OP_DROP;
      default:              op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Result buffer: storage, pointers, occupancy and the
// push/pop/drop decision for a no-backpressure producer.
module sync_fifo_core
  import result_fifo_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [W-1:0]           in_data,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [W-1:0]           out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   wr_en,
  output logic                   drop_en
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             pop;
  logic             push;
  logic             drop;
  fifo_op_e         op;

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign count     = cnt_q;

  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  assign op      = op_encode(clr, push, pop, drop);
  assign wr_en   = (op == OP_PUSH) || (op == OP_XFER);
  assign drop_en = (op == OP_DROP);

  assign out_data = out_valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy state; clr wins over any handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      unique case (op)
        OP_CLR: begin
          rd_ptr <= '0;
          wr_ptr <= '0;
          cnt_q  <= '0;
        end
        OP_PUSH: begin
          wr_ptr <= wr_ptr + 1'b1;
          cnt_q  <= cnt_q + 1'b1;
        end
        OP_POP: begin
          rd_ptr <= rd_ptr + 1'b1;
          cnt_q  <= cnt_q - 1'b1;
        end
        OP_XFER: begin
          rd_ptr <= rd_ptr + 1'b1;
          wr_ptr <= wr_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: rtl/result_fifo_acc.sv
// Adder result sink: FIFO, running sum and sticky drop flag.
// Optional macro RESULT_ACC_SAT_EN: saturating acc + acc_sat.
module result_fifo_acc
  import result_fifo_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [W-1:0]           in_data,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [W-1:0]           out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic [ACC_W-1:0]       acc,
`ifdef RESULT_ACC_SAT_EN
  output logic                   acc_sat,
`endif
  output logic                   overflow
);

  logic wr_en;
  logic drop_en;

  sync_fifo_core #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .wr_en     (wr_en),
    .drop_en   (drop_en)
  );

`ifdef RESULT_ACC_SAT_EN
  logic [ACC_W:0] sum;
  assign sum = {1'b0, acc} + (ACC_W + 1)'(in_data);

  // Saturating sum of accepted results; acc_sat is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      acc_sat  <= 1'b0;
      overflow <= 1'b0;
    end else if (clr) begin
      acc      <= '0;
      acc_sat  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        if (sum[ACC_W]) begin
          acc     <= '1;
          acc_sat <= 1'b1;
        end else begin
          acc <= sum[ACC_W-1:0];
        end
      end
      if (drop_en) begin
        overflow <= 1'b1;
      end
    end
  end
`else
  logic [ACC_W-1:0] sum;
  assign sum = acc + ACC_W'(in_data);

  // Wrapping sum of accepted results; drops set overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        acc <= sum;
      end
      if (drop_en) begin
        overflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_result_fifo_acc.sv
// Self-checking bench for result_fifo_acc against a
// queue-based reference model.
module tb_result_fifo_acc;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int ACC_W = 16;
  localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [2:0]   count;
  logic         full;
  logic [ACC_W-1:0] acc;
  logic         overflow;
`ifdef RESULT_ACC_SAT_EN
  logic         acc_sat;
`endif

  result_fifo_acc #(
    .W     (W),
    .DEPTH (DEPTH),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .acc       (acc),
`ifdef RESULT_ACC_SAT_EN
    .acc_sat   (acc_sat),
`endif
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] q[$];
  longint       m_acc;
  bit           m_ovf;
  bit           m_sat;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_acc = 0;
    m_ovf = 0;
    m_sat = 0;
  endtask

  task automatic model_step(input bit iv, input logic [W-1:0] d,
                            input bit rdy, input bit c);
    bit pop, push, drop, isfull;
    if (c) begin
      model_reset();
      return;
    end
    isfull = (q.size() == DEPTH);
    pop    = (q.size() != 0) && rdy;
    push   = iv && (!isfull || pop);
    drop   = iv && isfull && !pop;
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(d);
`ifdef RESULT_ACC_SAT_EN
      if (m_acc + d > ACC_MAX) begin
        m_acc = ACC_MAX;
        m_sat = 1;
      end else begin
        m_acc = m_acc + d;
      end
`else
      m_acc = (m_acc + d) % (ACC_MAX + 1);
`endif
    end
    if (drop) m_ovf = 1;
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("out_data", 32'(out_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk("acc", 32'(acc), 32'(m_acc));
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef RESULT_ACC_SAT_EN
    chk("acc_sat", 32'(acc_sat), 32'(m_sat));
`endif
  endtask

  task automatic cycle(input bit iv, input logic [W-1:0] d,
                       input bit rdy, input bit c);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    clr       = c;
    @(posedge clk);
    #1;
    model_step(iv, d, rdy, c);
    check_all();
  endtask

  initial begin
    logic [W-1:0] v;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    model_reset();
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // 1: three pushes, no consumer
    cycle(1, 8'h05, 0, 0);
    cycle(1, 8'h10, 0, 0);
    cycle(1, 8'hFF, 0, 0);
    chk("t1_count", 32'(count), 32'd3);
    chk("t1_acc", 32'(acc), 32'h114);
    chk("t1_head", 32'(out_data), 32'h05);
    chk("t1_ovf", 32'(overflow), 32'd0);

    // 2: fill, drop the fifth, drain in order
    cycle(0, 0, 0, 1);
    for (int i = 1; i <= 5; i++) begin
      cycle(1, W'(i), 0, 0);
      if (i == 4) chk("t2_full4", 32'(full), 32'd1);
    end
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_acc", 32'(acc), 32'd10);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_drain", 32'(out_data), 32'(i));
      cycle(0, 0, 1, 0);
    end
    chk("t2_empty", 32'(out_valid), 32'd0);

    // 3: full with simultaneous push and pop
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, W'(8'h20 + i), 0, 0);
    cycle(1, 8'h09, 1, 0);
    chk("t3_count", 32'(count), 32'd4);
    chk("t3_ovf", 32'(overflow), 32'd0);
    chk("t3_acc", 32'(acc), 32'(8'h20 + 8'h21 + 8'h22 + 8'h23 + 9));
    chk("t3_head", 32'(out_data), 32'h21);

    // 4: one-cycle latency, no bypass
    cycle(0, 0, 0, 1);
    cycle(1, 8'h33, 1, 0);
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_data", 32'(out_data), 32'h33);
    cycle(0, 0, 1, 0);
    chk("t4_count", 32'(count), 32'd0);

    // 5: clr beats a same-cycle push
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 8'h10, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    chk("t5_pre_count", 32'(count), 32'd2);
    chk("t5_pre_acc", 32'(acc), 32'h40);
    chk("t5_pre_ovf", 32'(overflow), 32'd1);
    cycle(1, 8'h77, 1, 1);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_acc", 32'(acc), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    chk("t5_valid", 32'(out_valid), 32'd0);

    // 5b: asynchronous reset mid-drain
    cycle(1, 8'h41, 0, 0);
    cycle(1, 8'h42, 0, 0);
    cycle(1, 8'h43, 1, 0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t5r_count", 32'(count), 32'd0);
    chk("t5r_valid", 32'(out_valid), 32'd0);
    chk("t5r_acc", 32'(acc), 32'd0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 1, 0);
    chk("t5r_after", 32'(out_valid), 32'd0);

    // 6: large sums, wrap or saturate
    cycle(0, 0, 0, 1);
    cycle(1, 8'hF0, 1, 0);
    cycle(1, 8'h20, 1, 0);
    chk("t6_acc1", 32'(acc), 32'h110);
    for (int i = 0; i < 300; i++) cycle(1, 8'hFF, 1, 0);
`ifdef RESULT_ACC_SAT_EN
    chk("t6_sat_acc", 32'(acc), 32'hFFFF);
    chk("t6_sat_flag", 32'(acc_sat), 32'd1);
    cycle(1, 8'h01, 1, 0);
    chk("t6_sat_hold", 32'(acc), 32'hFFFF);
`else
    chk("t6_wrap", 32'(acc), 32'((32'h110 + 300 * 255) % 65536));
    cycle(1, 8'h01, 1, 0);
    chk("t6_wrap1", 32'(acc), 32'((32'h111 + 300 * 255) % 65536));
`endif

    // 7: random traffic against the model
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      v = W'($urandom);
      cycle(bit'($urandom_range(0, 3) != 0), v,
            bit'($urandom_range(0, 2) == 0),
            bit'($urandom_range(0, 60) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/result_fifo_acc.md
Name: result_fifo_acc

Overview:
- Downstream consumer of the adder stage's (y, valid) result stream.
- The adder stage has no backpressure, so this block buffers each result in a small FIFO.
- Keeps a running accumulated sum of accepted results and a sticky overflow flag.
- Presents buffered results to the next stage over a valid/ready handshake.

Parameters:
- W, 8, data width; equals the adder stage's result width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ACC_W, 16, accumulator width; must be at least W.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of FIFO, accumulator and overflow flag.
- in_valid  input  1  result strobe from the adder stage (its valid).
- in_data  input  W  result from the adder stage (its y).
- out_ready  input  1  downstream ready.
- out_valid  output  1  head entry available.
- out_data  output  W  FIFO head entry.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- acc  output  ACC_W  running sum of accepted inputs.
- overflow  output  1  sticky: an input was dropped.

Behaviour:
- Reset (rst_n low, asynchronous): rd/wr pointers, count, acc and overflow go to 0.
  - Outputs: out_valid=0, full=0, out_data=0.
  - Storage array contents need not be reset.
- Handshake terms:
  - pop = out_valid && out_ready.
  - push = in_valid && (!full || pop).
  - drop = in_valid && full && !pop.
- Push: writes in_data at wr_ptr, then wr_ptr increments (wraps mod DEPTH).
- Pop: rd_ptr increments (wraps mod DEPTH).
- count update: +1 on push only; -1 on pop only; unchanged on push and pop together.
- out_valid = (count != 0).
- out_data = mem[rd_ptr] while out_valid; 0 when empty.
- No bypass: a push into an empty FIFO raises out_valid the next cycle, so in_valid to out_valid latency is 1 cycle.
- Full with simultaneous push and pop: both are performed, count stays DEPTH, and no drop occurs.
- Drop: in_data is discarded, overflow is set to 1 (sticky), and acc is unchanged.
- Accumulator:
  - On push, acc <= acc + zero-extended in_data.
  - Arithmetic is modulo 2^ACC_W (wraps) unless the optional feature is enabled.
- out_valid && !out_ready: head entry and out_data hold stable; the consumer sees no change until accepted.
- clr:
  - Highest priority after reset.
  - Pointers, count, acc and overflow go to 0 next cycle.
  - Any same-cycle push, pop or drop is ignored.
  - out_valid is 0 the following cycle.
- Reset asserted mid-stream discards all buffered entries. After release, the block behaves as empty.
- full and count are registered-state decodes with no combinational path from in_valid.

Optional Feature:
- Macro: RESULT_ACC_SAT_EN.
- Defined: on push, if acc + in_data would exceed 2^ACC_W-1, acc becomes all ones and stays there until clr or reset.
  - An extra output port acc_sat (1 bit, sticky, reset 0, cleared by clr) indicates saturation occurred.
- Undefined: acc wraps modulo 2^ACC_W, and the acc_sat port does not exist.

Decomposition:
- Package result_fifo_pkg holds:
  - default W/DEPTH/ACC_W constants;
  - pointer-width constant expression;
  - the push/pop/drop encoding enum, used for debug/coverage.
- Sub-module sync_fifo_core holds the storage array, pointers, count, full/empty and the push/pop/drop logic.
- The top-level holds the accumulator, overflow and optional saturation logic.

Test Plan:
1. Reset then 3 pushes of 0x05, 0x10, 0xFF with out_ready=0 -> count=3, acc=0x0114, out_data=0x05, overflow=0.
2. DEPTH=4: 5 consecutive in_valid pulses 1..5 with out_ready=0 -> full=1 after 4th, 5th dropped, overflow=1, acc=10; drain yields 1,2,3,4.
3. Full FIFO, in_valid=1 data 0x09 and out_ready=1 in the same cycle -> head popped, 0x09 written, count stays 4, overflow stays 0, acc +9.
4. Empty, push 0x33 with out_ready=1 held -> out_valid rises exactly 1 cycle after in_valid, popped that cycle, count back to 0.
5. count=2, acc=0x0040, overflow=1, then clr with simultaneous in_valid -> next cycle count=0, acc=0, overflow=0, out_valid=0; rst_n pulse mid-drain gives the same result asynchronously.
6. RESULT_ACC_SAT_EN, ACC_W=8: push 0xF0 then 0x20 -> acc=0xFF, acc_sat=1; further push 0x01 -> acc stays 0xFF. Without the macro, the same sequence gives acc=0x10 then 0x11.
